// File: rtl/alu_pkg.sv
// Shared types for the multi-pass ALU sequencer.
// Op codes, FSM states and the datapath slice width.
package alu_pkg;

  localparam int SLICE = 16;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic op_legal(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR)
        || (op == OP_ADD) || (op == OP_SUB)
        || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Request/response handshake bundle between
// execute-stage issue logic and the ALU sequencer.
interface alu_seq_ctrl_if #(
  parameter int WIDTH = 32
);

  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_r;
  logic             rsp_cout;
  logic             rsp_zero;
  logic             rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid, rsp_r, rsp_cout,
    input  rsp_zero, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    input  rsp_ready,
    output req_ready,
    output rsp_valid, rsp_r, rsp_cout,
    output rsp_zero, rsp_err
  );

endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequences WIDTH-bit ops over a 16-bit ALU slice,
// LSB half first, chaining carry between passes.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  alu_seq_ctrl_if.slave bus,
  output logic [2:0]  alu_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic        alu_cin,
  output logic        alu_lessi,
  input  logic [15:0] alu_r,
  input  logic        alu_cout
);

  localparam int NPASS = WIDTH / SLICE;
  localparam int PW = (NPASS > 1) ? $clog2(NPASS) : 1;
  localparam logic [PW-1:0] LAST = PW'(NPASS - 1);

  state_e           state_q, state_d;
  logic [PW-1:0]    pass_q, pass_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             err_q, err_d;

  logic             done;
  logic             r_msb;
  logic             ovf;
  logic             less;

  assign done = (state_q == DONE);

  assign bus.req_ready = (state_q == IDLE) && !reset;
  assign bus.rsp_valid = done;
  assign bus.rsp_r     = done ? res_q : '0;
  assign bus.rsp_cout  = done && cout_q;
  assign bus.rsp_err   = done && err_q;
  assign bus.rsp_zero  = done && (res_q == '0);

  assign alu_lessi = 1'b0;

  // Drive the ALU slice for the current pass; idle at zero
  always_comb begin
    alu_op  = 3'b000;
    alu_a   = '0;
    alu_b   = '0;
    alu_cin = 1'b0;
    if (state_q == RUN) begin
      alu_op = (op_q == OP_SLT) ? OP_SUB : op_q;
      alu_a  = a_q[int'(pass_q)*SLICE +: SLICE];
      alu_b  = b_q[int'(pass_q)*SLICE +: SLICE];
      if (pass_q == '0)
        alu_cin = (op_q == OP_SUB) || (op_q == OP_SLT);
      else
        alu_cin = carry_q && (op_q != OP_AND)
                          && (op_q != OP_OR);
    end
  end

  // Signed compare from the top pass: less = sign ^ overflow
  always_comb begin
    r_msb = alu_r[15];
    ovf   = (a_q[WIDTH-1] != b_q[WIDTH-1])
         && (r_msb != a_q[WIDTH-1]);
    less  = r_msb ^ ovf;
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          op_d    = bus.req_op;
          a_d     = bus.req_a;
          b_d     = bus.req_b;
          pass_d  = '0;
          res_d   = '0;
          carry_d = 1'b0;
          cout_d  = 1'b0;
          err_d   = !op_legal(bus.req_op);
          state_d = op_legal(bus.req_op) ? RUN : DONE;
        end
      end
      RUN: begin
        res_d[int'(pass_q)*SLICE +: SLICE] = alu_r;
        carry_d = alu_cout;
        pass_d  = pass_q + 1'b1;
        if (pass_q == LAST) begin
          state_d = DONE;
          pass_d  = '0;
          cout_d  = ((op_q == OP_ADD) || (op_q == OP_SUB))
                  && alu_cout;
          if (op_q == OP_SLT)
            res_d = WIDTH'(less);
        end
      end
      DONE: begin
        if (bus.rsp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pass_q  <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a 16-bit
// ALU slice model wired to the alu_* ports.
module tb_alu_seq_ctrl;

  localparam int W = 32;

  logic        clk;
  logic        reset;
  logic [2:0]  alu_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        alu_cin;
  logic        alu_lessi;
  logic [15:0] alu_r;
  logic        alu_cout;
  logic [16:0] alu_sum;

  int n_tests;
  int n_fail;

  logic [2:0] obs_op [0:7];
  logic       obs_cin [0:7];
  logic       alu_busy;
  int         lat;

  alu_seq_ctrl_if #(.WIDTH(W)) bus ();

  alu_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_cin   (alu_cin),
    .alu_lessi (alu_lessi),
    .alu_r     (alu_r),
    .alu_cout  (alu_cout)
  );

  // 16-bit ALU slice: bit 2 of ALUOp inverts b
  always_comb begin
    alu_sum = '0;
    case (alu_op)
      3'b000: alu_sum = {1'b0, alu_a & alu_b};
      3'b001: alu_sum = {1'b0, alu_a | alu_b};
      3'b010: alu_sum = {1'b0, alu_a}
                      + {1'b0, alu_b} + 17'(alu_cin);
      3'b110: alu_sum = {1'b0, alu_a}
                      + {1'b0, ~alu_b} + 17'(alu_cin);
      default: alu_sum = '0;
    endcase
  end
  assign alu_r    = alu_sum[15:0];
  assign alu_cout = alu_sum[16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [2:0] op,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
  endtask

  // Cycle holding an accepted request is cycle 0
  task automatic wait_rsp();
    lat = 0;
    alu_busy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      obs_op[i]  = 3'b000;
      obs_cin[i] = 1'b0;
    end
    alu_busy = |{alu_op, alu_a, alu_b, alu_cin};
    do begin
      tick();
      lat++;
      bus.req_valid = 1'b0;
      if (lat < 8) begin
        obs_op[lat]  = alu_op;
        obs_cin[lat] = alu_cin;
      end
      alu_busy |= |{alu_op, alu_a, alu_b, alu_cin};
    end while (!bus.rsp_valid && lat < 20);
  endtask

  task automatic chk_rsp(input string tag,
                         input logic [W-1:0] r,
                         input logic cout,
                         input logic zero,
                         input logic err,
                         input int exp_lat);
    check({tag, ".lat"}, 64'(lat), 64'(exp_lat));
    check({tag, ".r"}, bus.rsp_r, r);
    check({tag, ".cout"}, bus.rsp_cout, cout);
    check({tag, ".zero"}, bus.rsp_zero, zero);
    check({tag, ".err"}, bus.rsp_err, err);
  endtask

  task automatic handshake(input string tag);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check({tag, ".hs_valid"}, bus.rsp_valid, 1'b0);
    check({tag, ".hs_ready"}, bus.req_ready, 1'b1);
  endtask

  task automatic run(input string tag,
                     input logic [2:0] op,
                     input logic [W-1:0] a,
                     input logic [W-1:0] b,
                     input logic [W-1:0] r,
                     input logic cout,
                     input logic zero,
                     input int exp_lat);
    offer(op, a, b);
    wait_rsp();
    chk_rsp(tag, r, cout, zero, 1'b0, exp_lat);
    handshake(tag);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'b000;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    check("rst.req_ready", bus.req_ready, 1'b0);
    check("rst.rsp_valid", bus.rsp_valid, 1'b0);
    check("rst.rsp_r", bus.rsp_r, '0);
    check("rst.flags", {bus.rsp_cout, bus.rsp_zero,
                        bus.rsp_err}, 3'b000);
    reset = 1'b0;
    #1;
    check("idle.req_ready", bus.req_ready, 1'b1);

    // ADD with carry across the halves
    offer(3'b010, 32'h0000FFFF, 32'h00000001);
    wait_rsp();
    chk_rsp("add", 32'h00010000, 1'b0, 1'b0, 1'b0, 3);
    check("add.cin_p0", obs_cin[1], 1'b0);
    check("add.cin_p1", obs_cin[2], 1'b1);
    check("add.op_p0", obs_op[1], 3'b010);
    handshake("add");

    run("sub_eq", 3'b110, 32'd5, 32'd5,
        32'h0, 1'b1, 1'b1, 3);
    run("sub_brw", 3'b110, 32'd0, 32'd1,
        32'hFFFFFFFF, 1'b0, 1'b0, 3);

    offer(3'b111, 32'hFFFFFFFF, 32'h1);
    wait_rsp();
    chk_rsp("slt_neg", 32'h1, 1'b0, 1'b0, 1'b0, 3);
    check("slt.op_p0", obs_op[1], 3'b110);
    check("slt.op_p1", obs_op[2], 3'b110);
    check("slt.cin_p0", obs_cin[1], 1'b1);
    handshake("slt_neg");

    run("slt_ovf", 3'b111, 32'h7FFFFFFF, 32'h80000000,
        32'h0, 1'b0, 1'b1, 3);
    run("slt_min", 3'b111, 32'h80000000, 32'h1,
        32'h1, 1'b0, 1'b0, 3);
    run("or", 3'b001, 32'h12340000, 32'h00005678,
        32'h12345678, 1'b0, 1'b0, 3);

    // Backpressure with a second request waiting
    offer(3'b000, 32'hF0F0F0F0, 32'hFF00FF00);
    wait_rsp();
    chk_rsp("and", 32'hF000F000, 1'b0, 1'b0, 1'b0, 3);
    offer(3'b010, 32'd1, 32'd2);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp.valid", bus.rsp_valid, 1'b1);
      check("bp.r", bus.rsp_r, 32'hF000F000);
      check("bp.req_ready", bus.req_ready, 1'b0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("bp.hs_valid", bus.rsp_valid, 1'b0);
    check("bp.hs_ready", bus.req_ready, 1'b1);
    wait_rsp();
    chk_rsp("bp.next", 32'd3, 1'b0, 1'b0, 1'b0, 3);
    handshake("bp.next");

    // Illegal op: no ALU activity, immediate response
    offer(3'b011, 32'hDEADBEEF, 32'h12345678);
    wait_rsp();
    chk_rsp("ill", 32'h0, 1'b0, 1'b1, 1'b1, 1);
    check("ill.alu_idle", alu_busy, 1'b0);
    handshake("ill");

    // Reset during pass 1 of an ADD
    offer(3'b010, 32'h0000FFFF, 32'h00000001);
    tick();
    bus.req_valid = 1'b0;
    tick();
    check("ra.cin_p1", alu_cin, 1'b1);
    reset = 1'b1;
    #1;
    check("ra.req_ready", bus.req_ready, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    check("ra.rsp_valid", bus.rsp_valid, 1'b0);
    check("ra.rsp_r", bus.rsp_r, '0);
    check("ra.alu", {alu_op, alu_a, alu_b, alu_cin}, '0);
    check("ra.req_ready2", bus.req_ready, 1'b1);
    tick();
    check("ra.no_rsp", bus.rsp_valid, 1'b0);
    run("ra.add", 3'b010, 32'd1, 32'd2,
        32'd3, 1'b0, 1'b0, 3);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Multi-cycle sequencer that performs WIDTH-bit ALU operations on the shared 16-bit carry-lookahead ALU slice, one 16-bit pass per cycle, LSB half first.
- Carry chains between passes. 32-bit SLT is resolved in the controller from sign and overflow.
- Sits between the execute-stage issue logic (valid/ready request) and the ALU16 datapath. Drives the datapath combinationally from its own registers.

Parameters:
- WIDTH, 32, operand width; multiple of 16, range 16..64.
- NPASS, WIDTH/16, derived local constant; not overridable.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request offered.
- req_ready  out  1  controller can accept.
- req_op  in  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; other codes illegal.
- req_a  in  WIDTH  operand a.
- req_b  in  WIDTH  operand b.
- alu_op  out  3  ALUOp to the 16-bit ALU.
- alu_a  out  16  a slice for the current pass.
- alu_b  out  16  b slice for the current pass.
- alu_cin  out  1  carry into the current pass.
- alu_lessi  out  1  tied 0.
- alu_r  in  16  ALU result.
- alu_cout  in  1  ALU carry out.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts.
- rsp_r  out  WIDTH  result.
- rsp_cout  out  1  final carry (ADD/SUB); 0 otherwise.
- rsp_zero  out  1  rsp_r == 0.
- rsp_err  out  1  illegal op.

Behaviour:
- Reset:
  - State goes to IDLE. Pass counter, operand, result and carry registers clear to 0.
  - rsp_valid, rsp_r, rsp_cout, rsp_zero, rsp_err all 0.
  - req_ready is 0 while reset is high.
  - Reset mid-operation aborts the operation. Nothing is emitted for it.
- States: IDLE, RUN, DONE.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch op/a/b, clear pass = 0 and result.
  - Legal op goes to RUN. Illegal op goes straight to DONE with rsp_err = 1 and rsp_r = 0.
  - alu_* outputs are 0.
- RUN, pass p:
  - alu_a = a_q[16p+15:16p], alu_b = b_q[16p+15:16p].
  - alu_op = op_q, except SLT, which drives 110 (SUB).
  - alu_cin:
    - p == 0: 1 for SUB/SLT, 0 otherwise.
    - p > 0: registered alu_cout of pass p-1 for ADD/SUB/SLT; 0 for AND/OR.
  - Each edge stores alu_r into result slice p, registers alu_cout, and increments p.
  - After pass NPASS-1, go to DONE.
- DONE entry values:
  - ADD/SUB: rsp_cout = final carry.
  - SLT: less = r_msb XOR ovf, where ovf = (a_msb != b_msb) && (r_msb != a_msb); rsp_r = {0..., less}; rsp_cout = 0.
  - rsp_zero is computed from the final rsp_r.
- DONE:
  - rsp_valid = 1; outputs held stable until rsp_ready.
  - On rsp_ready, return to IDLE and drop rsp_valid.
- No overlap: req_ready = 0 in RUN and DONE. A new request is accepted the cycle after the handshake completes.
- Latency: accept at edge 0, rsp_valid high from edge NPASS+1 (3 cycles at WIDTH=32). Illegal op: rsp_valid from edge 1.
- Arithmetic is modulo 2^WIDTH. Carry is unsigned carry-out; for SUB, cout = 1 means no borrow.

Decomposition:
- Shared package alu_pkg:
  - ALUOp codes: OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT.
  - State encoding: IDLE, RUN, DONE.
  - Slice width constant SLICE = 16.
- No sub-module required.
- The bench instantiates the existing 16-bit CLA ALU and wires it to the alu_* ports.

Test Plan:
- ADD a=0x0000FFFF b=0x00000001 -> rsp_r=0x00010000, cout=0, zero=0; rsp_valid exactly 3 cycles after accept; alu_cin=1 on pass 1.
- SUB a=5 b=5 -> rsp_r=0, zero=1, cout=1. SUB a=0 b=1 -> rsp_r=0xFFFFFFFF, cout=0.
- SLT:
  - a=0xFFFFFFFF b=1 -> rsp_r=1.
  - a=0x7FFFFFFF b=0x80000000 -> rsp_r=0 (overflow case).
  - a=0x80000000 b=1 -> rsp_r=1.
  - alu_op observed as 110 on both passes.
- Backpressure: AND a=0xF0F0F0F0 b=0xFF00FF00 -> 0xF000F000. Hold rsp_ready=0 for 5 cycles: outputs stable, req_ready=0, a second req_valid is not accepted until the cycle after the handshake.
- Illegal op 011 -> rsp_err=1, rsp_r=0, rsp_valid 1 cycle after accept, no ALU passes (alu_* remain 0).
- Reset asserted during pass 1 of an ADD -> next cycle state IDLE, rsp_valid=0, all outputs 0; a following ADD 1+2 returns 3 with correct latency.
